sdram_port_arbiter: RTL

//  Two-port Avalon-MM arbiter that shares the single SDRAM controller port (wMEM_CLK domain) between
//  the video framebuffer reader (port 0, priority) and the JTAG/host bridge (port 1).

---
 rtl/sdram_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller Avalon-MM port between a priority video reader (port 0) and a host bridge (port 1).
// Write bursts hold the grant until their last beat; read beats return to their issuer through an in-order tag FIFO.
module sdram_port_arbiter #(
  parameter int AW       = 22,
  parameter int DW       = 16,
  parameter int BW       = 5,
  parameter int MAXPEND  = 4,
  parameter int HP_LIMIT = 8
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [AW-1:0]     iP0_ADDRESS,
  input  logic              iP0_READ,
  input  logic              iP0_WRITE,
  input  logic [DW-1:0]     iP0_WRITE_DATA,
  input  logic [DW/8-1:0]   iP0_BYTE_ENABLE,
  input  logic [BW-1:0]     iP0_BURST_COUNT,
  output logic              oP0_WAIT_REQUEST,
  output logic [DW-1:0]     oP0_READ_DATA,
  output logic              oP0_READ_DATAVALID,
  input  logic [AW-1:0]     iP1_ADDRESS,
  input  logic              iP1_READ,
  input  logic              iP1_WRITE,
  input  logic [DW-1:0]     iP1_WRITE_DATA,
  input  logic [DW/8-1:0]   iP1_BYTE_ENABLE,
  input  logic [BW-1:0]     iP1_BURST_COUNT,
  output logic              oP1_WAIT_REQUEST,
  output logic [DW-1:0]     oP1_READ_DATA,
  output logic              oP1_READ_DATAVALID,
  output logic [AW-1:0]     oM_ADDRESS,
  output logic [DW-1:0]     oM_WRITE_DATA,
  output logic [DW/8-1:0]   oM_BYTE_ENABLE,
  output logic [BW-1:0]     oM_BURST_COUNT,
  output logic              oM_READ,
  output logic              oM_WRITE,
  input  logic              iM_WAIT_REQUEST,
  input  logic [DW-1:0]     iM_READ_DATA,
  input  logic              iM_READ_DATAVALID,
  output logic              oERR_ORPHAN
);
  // state    | meaning
  // IDLE     | controller port free; choose the next grant
  // RD_CMD   | granted port's read command presented until accepted
  // WR_BURST | granted port owns the controller until its last write beat
  typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;

  localparam int PW = $clog2(MAXPEND);
  localparam int HW = $clog2(HP_LIMIT + 1);

  state_t                      state;
  logic                        gnt;
  logic                        m_read;
  logic [BW-1:0]               wr_left;
  logic [HW-1:0]               hp_cnt;
  logic [PW:0]                 fifo_cnt;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [MAXPEND-1:0]          tag_port;
  logic [MAXPEND-1:0][BW-1:0]  tag_len;
  logic                        ret_busy;
  logic [BW-1:0]               ret_left;

  logic p0_rd, p0_wr, p1_rd, p1_wr, p0_ok, p1_ok, p1_req;
  logic fifo_full, fifo_empty, hp_max, pick_p1, any_ok;
  logic [BW-1:0] p0_len, p1_len, g_len, cur_left;
  logic g_write, rd_acc, wr_acc, busy, beat, pop, head_port;

  // READ wins when a port raises both strobes
  assign p0_rd  = iP0_READ;
  assign p0_wr  = iP0_WRITE & ~iP0_READ;
  assign p1_rd  = iP1_READ;
  assign p1_wr  = iP1_WRITE & ~iP1_READ;
  assign p1_req = iP1_READ | iP1_WRITE;

  assign fifo_full  = (fifo_cnt == (PW+1)'(MAXPEND));
  assign fifo_empty = (fifo_cnt == '0);
  assign p0_ok      = p0_wr | (p0_rd & ~fifo_full);
  assign p1_ok      = p1_wr | (p1_rd & ~fifo_full);
  assign hp_max     = (hp_cnt == HW'(HP_LIMIT));
  assign pick_p1    = p1_ok & (hp_max | ~p0_ok);
  assign any_ok     = p0_ok | p1_ok;

  assign p0_len = (iP0_BURST_COUNT == '0) ? BW'(1) : iP0_BURST_COUNT;
  assign p1_len = (iP1_BURST_COUNT == '0) ? BW'(1) : iP1_BURST_COUNT;
  assign g_len  = gnt ? p1_len : p0_len;

  assign oM_ADDRESS     = gnt ? iP1_ADDRESS     : iP0_ADDRESS;
  assign oM_WRITE_DATA  = gnt ? iP1_WRITE_DATA  : iP0_WRITE_DATA;
  assign oM_BYTE_ENABLE = gnt ? iP1_BYTE_ENABLE : iP0_BYTE_ENABLE;
  assign oM_BURST_COUNT = g_len;
  assign g_write        = gnt ? iP1_WRITE : iP0_WRITE;

  assign oM_READ  = m_read;
  assign oM_WRITE = (state == WR_BURST) & g_write;
  assign rd_acc   = m_read & ~iM_WAIT_REQUEST;
  assign wr_acc   = oM_WRITE & ~iM_WAIT_REQUEST;
  assign busy     = (state != IDLE);

  assign oP0_WAIT_REQUEST = ~(busy & ~gnt) | iM_WAIT_REQUEST;
  assign oP1_WAIT_REQUEST = ~(busy &  gnt) | iM_WAIT_REQUEST;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      m_read  <= 1'b0;
      wr_left <= '0;
      hp_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (any_ok) begin
          gnt <= pick_p1;
          if (pick_p1 ? p1_rd : p0_rd) begin
            state  <= RD_CMD;
            m_read <= 1'b1;
          end else begin
            state   <= WR_BURST;
            wr_left <= pick_p1 ? p1_len : p0_len;
          end
        end
        RD_CMD: if (rd_acc) begin
          state  <= IDLE;
          m_read <= 1'b0;
        end
        WR_BURST: if (wr_acc) begin
          if (wr_left == BW'(1)) state <= IDLE;
          else                   wr_left <= wr_left - BW'(1);
        end
        default: state <= IDLE;
      endcase

      // starvation counter only advances at a port-0 grant while port 1 waits
      if (!p1_req)
        hp_cnt <= '0;
      else if (state == IDLE && any_ok) begin
        if (pick_p1)      hp_cnt <= '0;
        else if (!hp_max) hp_cnt <= hp_cnt + HW'(1);
      end
    end
  end

  assign head_port = tag_port[rd_ptr];
  assign beat      = iM_READ_DATAVALID & ~fifo_empty;
  assign cur_left  = ret_busy ? ret_left : tag_len[rd_ptr];
  assign pop       = beat & (cur_left == BW'(1));

  assign oP0_READ_DATA      = iM_READ_DATA;
  assign oP1_READ_DATA      = iM_READ_DATA;
  assign oP0_READ_DATAVALID = beat & ~head_port;
  assign oP1_READ_DATAVALID = beat &  head_port;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      tag_port    <= '0;
      tag_len     <= '0;
      ret_busy    <= 1'b0;
      ret_left    <= '0;
      oERR_ORPHAN <= 1'b0;
    end else begin
      if (rd_acc) begin
        tag_port[wr_ptr] <= gnt;
        tag_len[wr_ptr]  <= g_len;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + (PW+1)'(rd_acc) - (PW+1)'(pop);
      if (beat) begin
        ret_busy <= ~pop;
        ret_left <= cur_left - BW'(1);
      end
      // a same-cycle push does not rescue a beat that arrives with nothing outstanding
      if (iM_READ_DATAVALID && fifo_empty) oERR_ORPHAN <= 1'b1;
    end
  end
endmodule
